wb_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single Wishbone slave (memory model) between NUM_M Wishbone masters.
- Master 0 is the ahb2wb bridge; further ports serve DMA or testbench masters.
- Sits between the masters' cyc/stb/we/adr/dat buses and the slave.
- Holds each grant for a whole cyc tenure and guards the slave with an ack watchdog.

---
 rtl/wb_arb_pkg.sv | 19 +
 rtl/wb_rr_arbiter_if.sv | 40 ++++
 rtl/wb_rr_pick.sv | 33 +++
 rtl/wb_rr_arbiter.sv | 125 ++++++++++++
 tb/tb_wb_rr_arbiter.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and defaults for the Wishbone round-robin arbiter
package wb_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_M   = 2;
    localparam int DEF_AW      = 32;
    localparam int DEF_DW      = 32;
    localparam int DEF_TIMEOUT = 16;

    // Index width for n items; never below one bit so a 2-entry index still has storage.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// rtl/wb_rr_arbiter_if.sv - master-side and slave-side Wishbone bundle around the arbiter
interface wb_rr_arbiter_if
    import wb_arb_pkg::*;
#(
    parameter int NUM_M = DEF_NUM_M,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
);
    logic [NUM_M-1:0]    m_cyc_i;
    logic [NUM_M-1:0]    m_stb_i;
    logic [NUM_M-1:0]    m_we_i;
    logic [NUM_M*AW-1:0] m_adr_i;
    logic [NUM_M*DW-1:0] m_dat_i;
    logic [DW-1:0]       m_dat_o;
    logic [NUM_M-1:0]    m_ack_o;
    logic [NUM_M-1:0]    m_err_o;
    logic [NUM_M-1:0]    gnt_o;
    logic                s_cyc_o;
    logic                s_stb_o;
    logic                s_we_o;
    logic [AW-1:0]       s_adr_o;
    logic [DW-1:0]       s_dat_o;
    logic [DW-1:0]       s_dat_i;
    logic                s_ack_i;

    // The arbiter is the slave of the masters and drives the shared memory slave.
    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
        output m_dat_o, m_ack_o, m_err_o, gnt_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o
    );

    // Masters plus the memory model, seen from outside the arbiter.
    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
        input  m_dat_o, m_ack_o, m_err_o, gnt_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o
    );

endinterface

// File: rtl/wb_rr_pick.sv
// rtl/wb_rr_pick.sv - combinational round-robin selector searching from last+1 upward
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter  int NUM_M = DEF_NUM_M,
    localparam int IW    = idx_w(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [NUM_M-1:0] gnt_next,
    output logic [IW-1:0]    index,
    output logic             valid
);

    logic [IW-1:0] k;

    // The previous owner is visited last, so it only wins when nobody else asks.
    always_comb begin
        gnt_next = '0;
        index    = '0;
        valid    = 1'b0;
        k        = '0;
        for (int i = 1; i <= NUM_M; i++) begin
            k = IW'((int'(last) + i) % NUM_M);
            if (!valid && req[k]) begin
                valid       = 1'b1;
                gnt_next[k] = 1'b1;
                index       = k;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - round-robin Wishbone arbiter with per-tenure grant and ack watchdog
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_M   = DEF_NUM_M,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    wb_rr_arbiter_if.slave  bus
);

    localparam int            IW       = idx_w(NUM_M);
    localparam int            WW       = idx_w(TIMEOUT);
    localparam logic [WW-1:0] WDOG_MAX = WW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_M - 1);

    arb_state_t       state_q, state_d;
    logic [NUM_M-1:0] gnt_q, gnt_d;
    logic [NUM_M-1:0] err_q, err_d;
    logic [IW-1:0]    gidx_q, gidx_d;
    logic [IW-1:0]    last_q, last_d;
    logic [WW-1:0]    wdog_q, wdog_d;
    logic             errp_q, errp_d;

    logic [NUM_M-1:0] pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;

    logic             own;
    logic             stb_out;
    logic             ack_fwd;

    wb_rr_pick #(.NUM_M(NUM_M)) u_pick (
        .req      (bus.m_cyc_i),
        .last     (last_q),
        .gnt_next (pick_gnt),
        .index    (pick_idx),
        .valid    (pick_valid)
    );

    always_comb begin
        own     = (state_q == OWN);
        stb_out = own & bus.m_stb_i[gidx_q] & ~errp_q;
        ack_fwd = stb_out & bus.s_ack_i;
    end

    // Slave side is gated by OWN so everything reads zero while idle or in reset.
    assign bus.s_cyc_o = own & bus.m_cyc_i[gidx_q];
    assign bus.s_stb_o = stb_out;
    assign bus.s_we_o  = own & bus.m_we_i[gidx_q];
    assign bus.s_adr_o = own ? bus.m_adr_i[int'(gidx_q)*AW +: AW] : '0;
    assign bus.s_dat_o = own ? bus.m_dat_i[int'(gidx_q)*DW +: DW] : '0;
    assign bus.m_dat_o = bus.s_dat_i;
    assign bus.m_ack_o = gnt_q & {NUM_M{ack_fwd}};
    assign bus.m_err_o = err_q;
    assign bus.gnt_o   = gnt_q;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        errp_d  = errp_q;
        err_d   = '0;
        case (state_q)
            IDLE: begin
                wdog_d = '0;
                errp_d = 1'b0;
                if (pick_valid) begin
                    state_d = OWN;
                    gnt_d   = pick_gnt;
                    gidx_d  = pick_idx;
                end
            end
            OWN: begin
                if (!bus.m_cyc_i[gidx_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    last_d  = gidx_q;
                    wdog_d  = '0;
                    errp_d  = 1'b0;
                end else begin
                    if (errp_q && !bus.m_stb_i[gidx_q])
                        errp_d = 1'b0;
                    // Counter restarts on the timeout itself, so it can never wrap.
                    if (!stb_out || bus.s_ack_i) begin
                        wdog_d = '0;
                    end else if (wdog_q == WDOG_MAX) begin
                        wdog_d = '0;
                        errp_d = 1'b1;
                        err_d  = gnt_q;
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            err_q   <= '0;
            gidx_q  <= '0;
            last_q  <= LAST_RST;
            wdog_q  <= '0;
            errp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            err_q   <= err_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
            errp_q  <= errp_d;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb/tb_wb_rr_arbiter.sv - directed self-checking bench for wb_rr_arbiter
module tb_wb_rr_arbiter;

    localparam int NUM_M   = 2;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          auto_ack = 1'b0;
    logic          man_ack = 1'b0;
    logic [DW-1:0] rdata = '0;
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    wb_rr_arbiter_if #(.NUM_M(NUM_M), .AW(AW), .DW(DW)) bus ();

    wb_rr_arbiter #(.NUM_M(NUM_M), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    // Zero-wait memory model when auto_ack is set, otherwise the test drives ack by hand.
    assign bus.s_ack_i = auto_ack ? (bus.s_cyc_o & bus.s_stb_o) : man_ack;
    assign bus.s_dat_i = rdata;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.m_cyc_i = 2'b11;
        bus.m_stb_i = 2'b11;
        bus.m_we_i  = 2'b00;
        bus.m_adr_i = {32'h2000_0000, 32'h1000_0000};
        bus.m_dat_i = {32'h2222_2222, 32'h1111_1111};
        #13;
        rst_i = 1'b1;
        #1;
        total++; if (bus.gnt_o !== 2'b00) begin bad++; $display("FAIL rst_gnt: got %b expected 00", bus.gnt_o); end
        total++; if ({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o} !== 3'b000) begin bad++; $display("FAIL rst_slave_ctl: got %b expected 000", {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o}); end
        total++; if ({bus.m_ack_o, bus.m_err_o} !== 4'b0000) begin bad++; $display("FAIL rst_ack_err: got %b expected 0000", {bus.m_ack_o, bus.m_err_o}); end
        total++; if (bus.s_adr_o !== 32'h0) begin bad++; $display("FAIL rst_adr: got %h expected 00000000", bus.s_adr_o); end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        total++; if ({bus.gnt_o, bus.s_cyc_o} !== 3'b000) begin bad++; $display("FAIL rst_release_cycle: got %b expected 000", {bus.gnt_o, bus.s_cyc_o}); end
        @(negedge clk);
        total++; if (bus.gnt_o !== 2'b01) begin bad++; $display("FAIL first_gnt: got %b expected 01", bus.gnt_o); end
        total++; if (bus.s_cyc_o !== 1'b1) begin bad++; $display("FAIL first_cyc: got %b expected 1", bus.s_cyc_o); end
        total++; if (bus.s_adr_o !== 32'h1000_0000) begin bad++; $display("FAIL first_adr: got %h expected 10000000", bus.s_adr_o); end
        step();
        bus.m_cyc_i = 2'b00;
        bus.m_stb_i = 2'b00;
        step();
        step();
    endtask

    task automatic test_single_m1();
        bus.m_adr_i[63:32] = 32'h0000_0040;
        bus.m_dat_i[63:32] = 32'hA5A5_5A5A;
        bus.m_we_i  = 2'b10;
        bus.m_stb_i = 2'b10;
        bus.m_cyc_i = 2'b10;
        @(negedge clk);
        total++; if (bus.s_cyc_o !== 1'b0) begin bad++; $display("FAIL single_latency: got %b expected 0", bus.s_cyc_o); end
        step();
        @(negedge clk);
        total++; if (bus.gnt_o !== 2'b10) begin bad++; $display("FAIL single_gnt: got %b expected 10", bus.gnt_o); end
        total++; if ({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o} !== 3'b111) begin bad++; $display("FAIL single_ctl: got %b expected 111", {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o}); end
        total++; if (bus.s_adr_o !== 32'h0000_0040) begin bad++; $display("FAIL single_adr: got %h expected 00000040", bus.s_adr_o); end
        total++; if (bus.s_dat_o !== 32'hA5A5_5A5A) begin bad++; $display("FAIL single_dat: got %h expected a5a55a5a", bus.s_dat_o); end
        total++; if (bus.m_ack_o !== 2'b00) begin bad++; $display("FAIL single_wait1: got %b expected 00", bus.m_ack_o); end
        step();
        @(negedge clk);
        total++; if (bus.m_ack_o !== 2'b00) begin bad++; $display("FAIL single_wait2: got %b expected 00", bus.m_ack_o); end
        step();
        man_ack = 1'b1;
        @(negedge clk);
        total++; if (bus.m_ack_o !== 2'b10) begin bad++; $display("FAIL single_ack: got %b expected 10", bus.m_ack_o); end
        step();
        man_ack = 1'b0;
        bus.m_cyc_i = 2'b00;
        bus.m_stb_i = 2'b00;
        bus.m_we_i  = 2'b00;
        @(negedge clk);
        total++; if ({bus.m_ack_o, bus.s_cyc_o} !== 3'b000) begin bad++; $display("FAIL single_release: got %b expected 000", {bus.m_ack_o, bus.s_cyc_o}); end
        step();
        step();
        man_ack = 1'b1;
        @(negedge clk);
        total++; if ({bus.m_ack_o, bus.gnt_o} !== 4'b0000) begin bad++; $display("FAIL idle_ack_ignored: got %b expected 0000", {bus.m_ack_o, bus.gnt_o}); end
        step();
        man_ack = 1'b0;
        @(negedge clk);
        total++; if (bus.gnt_o !== 2'b00) begin bad++; $display("FAIL idle_stays: got %b expected 00", bus.gnt_o); end
    endtask

    task automatic test_fairness();
        int         seq[4];
        int         ten;
        int         gap;
        int         acks_in_ten;
        int         cycles;
        int         beats[2];
        logic [1:0] relaunch;
        logic [1:0] prev_gnt;
        int         exp_seq[4];
        exp_seq  = '{0, 1, 0, 1};
        seq      = '{-1, -1, -1, -1};
        ten = 0; gap = 0; acks_in_ten = 0; cycles = 0;
        beats    = '{0, 0};
        relaunch = 2'b00;
        prev_gnt = 2'b00;
        step();
        auto_ack    = 1'b1;
        bus.m_we_i  = 2'b11;
        bus.m_cyc_i = 2'b11;
        bus.m_stb_i = 2'b11;
        while (cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (bus.gnt_o != 2'b00 && prev_gnt == 2'b00) begin
                if (ten > 0) begin
                    total++; if (gap !== 1) begin bad++; $display("FAIL fair_gap: got %0d idle cycles expected 1", gap); end
                end
                if (ten < 4) seq[ten] = int'(bus.gnt_o[1]);
                ten++;
                acks_in_ten = 0;
            end
            if (bus.gnt_o == 2'b00 && prev_gnt != 2'b00) begin
                total++; if (acks_in_ten !== 4) begin bad++; $display("FAIL fair_burst_len: got %0d expected 4", acks_in_ten); end
            end
            gap = (bus.gnt_o == 2'b00) ? gap + 1 : 0;
            total++; if ((bus.m_ack_o & ~bus.gnt_o) !== 2'b00) begin bad++; $display("FAIL fair_interleave: ack %b gnt %b expected ack only to holder", bus.m_ack_o, bus.gnt_o); end
            if (bus.m_ack_o != 2'b00) acks_in_ten++;
            for (int k = 0; k < 2; k++) if (bus.m_ack_o[k]) beats[k]++;
            prev_gnt = bus.gnt_o;
            if (ten >= 4 && bus.gnt_o == 2'b00) break;
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (relaunch[k]) begin
                    bus.m_cyc_i[k] = 1'b1;
                    bus.m_stb_i[k] = 1'b1;
                    relaunch[k]    = 1'b0;
                end else if (beats[k] == 4) begin
                    bus.m_cyc_i[k] = 1'b0;
                    bus.m_stb_i[k] = 1'b0;
                    beats[k]       = 0;
                    relaunch[k]    = 1'b1;
                end
            end
        end
        total++; if (cycles >= 200) begin bad++; $display("FAIL fair_timeout: got %0d cycles expected under 200", cycles); end
        bus.m_cyc_i = 2'b00;
        bus.m_stb_i = 2'b00;
        bus.m_we_i  = 2'b00;
        auto_ack    = 1'b0;
        for (int t = 0; t < 4; t++) begin
            total++; if (seq[t] !== exp_seq[t]) begin bad++; $display("FAIL fair_seq%0d: got %0d expected %0d", t, seq[t], exp_seq[t]); end
        end
        step();
        step();
    endtask

    task automatic test_hold();
        int beats;
        beats = 0;
        rdata = 32'hDEAD_BEEF;
        auto_ack = 1'b1;
        bus.m_adr_i[31:0] = 32'h0000_0100;
        bus.m_we_i  = 2'b00;
        bus.m_cyc_i = 2'b01;
        bus.m_stb_i = 2'b01;
        step();
        for (int c = 0; c < 40 && beats < 8; c++) begin
            @(negedge clk);
            total++; if (bus.gnt_o !== 2'b01) begin bad++; $display("FAIL hold_gnt_c%0d: got %b expected 01", c, bus.gnt_o); end
            if (c == 0) begin
                total++; if (bus.m_dat_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL hold_rdata: got %h expected deadbeef", bus.m_dat_o); end
            end
            if (bus.m_ack_o[0]) beats++;
            step();
            if (c == 1) begin
                bus.m_cyc_i[1] = 1'b1;
                bus.m_stb_i[1] = 1'b1;
            end
        end
        total++; if (beats !== 8) begin bad++; $display("FAIL hold_beats: got %0d expected 8", beats); end
        bus.m_cyc_i[0] = 1'b0;
        bus.m_stb_i[0] = 1'b0;
        @(negedge clk);
        total++; if (bus.gnt_o !== 2'b01) begin bad++; $display("FAIL hold_fall_c0: got %b expected 01", bus.gnt_o); end
        step();
        @(negedge clk);
        total++; if (bus.gnt_o !== 2'b00) begin bad++; $display("FAIL hold_fall_c1: got %b expected 00", bus.gnt_o); end
        step();
        @(negedge clk);
        total++; if (bus.gnt_o !== 2'b10) begin bad++; $display("FAIL hold_fall_c2: got %b expected 10", bus.gnt_o); end
        step();
        bus.m_cyc_i = 2'b00;
        bus.m_stb_i = 2'b00;
        auto_ack = 1'b0;
        step();
        step();
    endtask

    task automatic test_watchdog();
        bus.m_we_i  = 2'b00;
        bus.m_cyc_i = 2'b11;
        bus.m_stb_i = 2'b11;
        step();
        for (int n = 1; n <= TIMEOUT; n++) begin
            @(negedge clk);
            total++; if ({bus.s_stb_o, bus.m_err_o} !== 3'b100) begin bad++; $display("FAIL wdog_stb%0d: got stb,err %b expected 100", n, {bus.s_stb_o, bus.m_err_o}); end
            step();
        end
        @(negedge clk);
        total++; if (bus.m_err_o !== 2'b01) begin bad++; $display("FAIL wdog_err: got %b expected 01", bus.m_err_o); end
        total++; if (bus.s_stb_o !== 1'b0) begin bad++; $display("FAIL wdog_stb_block: got %b expected 0", bus.s_stb_o); end
        step();
        man_ack = 1'b1;
        @(negedge clk);
        total++; if ({bus.m_err_o, bus.s_stb_o, bus.m_ack_o} !== 5'b00000) begin bad++; $display("FAIL wdog_after: got err,stb,ack %b expected 00000", {bus.m_err_o, bus.s_stb_o, bus.m_ack_o}); end
        step();
        man_ack = 1'b0;
        bus.m_stb_i[0] = 1'b0;
        @(negedge clk);
        total++; if ({bus.gnt_o, bus.s_stb_o} !== 3'b010) begin bad++; $display("FAIL wdog_keep_gnt: got %b expected 010", {bus.gnt_o, bus.s_stb_o}); end
        step();
        bus.m_cyc_i[0] = 1'b0;
        step();
        @(negedge clk);
        total++; if (bus.gnt_o !== 2'b00) begin bad++; $display("FAIL wdog_idle: got %b expected 00", bus.gnt_o); end
        step();
        @(negedge clk);
        total++; if (bus.gnt_o !== 2'b10) begin bad++; $display("FAIL wdog_next_m1: got %b expected 10", bus.gnt_o); end
    endtask

    task automatic test_mid_reset();
        bus.m_cyc_i = 2'b11;
        bus.m_stb_i = 2'b11;
        @(negedge clk);
        total++; if ({bus.gnt_o, bus.s_cyc_o, bus.s_stb_o} !== 4'b1011) begin bad++; $display("FAIL mid_pre: got %b expected 1011", {bus.gnt_o, bus.s_cyc_o, bus.s_stb_o}); end
        #2;
        rst_i = 1'b1;
        #1;
        total++; if ({bus.gnt_o, bus.s_cyc_o, bus.s_stb_o} !== 4'b0000) begin bad++; $display("FAIL mid_async: got %b expected 0000", {bus.gnt_o, bus.s_cyc_o, bus.s_stb_o}); end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        total++; if (bus.gnt_o !== 2'b00) begin bad++; $display("FAIL mid_release: got %b expected 00", bus.gnt_o); end
        @(negedge clk);
        total++; if (bus.gnt_o !== 2'b01) begin bad++; $display("FAIL mid_prio_m0: got %b expected 01", bus.gnt_o); end
        step();
        bus.m_cyc_i = 2'b00;
        bus.m_stb_i = 2'b00;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_m1();
        test_fairness();
        test_hold();
        test_watchdog();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
